verilab_gpio_in_conditioner: RTL

Input-side conditioning stage for the project GPIO bank. It synchronises asynchronous pad inputs into the core clock domain, debounces each bit independently, and detects rising and falling edges on the debounced value. Edges are captured as sticky per-bit pending flags with a combined interrupt. The block sits directly upstream of the core's GPIO consumers, and its width tracks the project-wide GPIO maximum.

---
 rtl/verilab_gpio_in_conditioner.sv | 102 ++++++++++
 1 files changed

// File: rtl/verilab_gpio_in_conditioner.sv
// GPIO input conditioner. Each bit is synchronised, debounced and
// edge-detected on its own. Edges latch into sticky pending flags, and a
// registered, masked OR of those flags drives a single interrupt line.

package proj_param_pkg;
  localparam int PROJ_GPIO = 8;
endpackage

module verilab_gpio_in_conditioner #(
  parameter int GPIO     = proj_param_pkg::PROJ_GPIO,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = $clog2(DEBOUNCE + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [GPIO-1:0] gpio_in,
  input  logic [GPIO-1:0] rise_en,
  input  logic [GPIO-1:0] fall_en,
  input  logic [GPIO-1:0] pend_clr,
  input  logic [GPIO-1:0] irq_mask,
  output logic [GPIO-1:0] gpio_db,
  output logic [GPIO-1:0] pending,
  output logic            irq
);

  // Terminal count: once s2 has disagreed for this many cycles, the
  // next disagreeing edge commits the new level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [GPIO-1:0]            s1;
  logic [GPIO-1:0]            s2;
  logic [GPIO-1:0]            db_q;
  logic [GPIO-1:0]            db_next;
  logic [GPIO-1:0][CNT_W-1:0] cnt;
  logic [GPIO-1:0][CNT_W-1:0] cnt_next;
  logic [GPIO-1:0]            rise;
  logic [GPIO-1:0]            fall;
  logic [GPIO-1:0]            pend_q;
  logic [GPIO-1:0]            pend_next;
  logic                       irq_q;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
    end
  end

  // Per-bit debounce. The counter runs while s2 disagrees with the
  // debounced level. Any agreement clears the counter, so a short glitch
  // never reaches the output. Reaching CNT_MAX commits the new level.
  always_comb begin
    db_next  = db_q;
    cnt_next = cnt;
    for (int i = 0; i < GPIO; i++) begin
      if (s2[i] != db_q[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_next[i]  = s2[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end else begin
        cnt_next[i] = '0;
      end
    end
  end

  // Edge detect on the debounced level, then sticky capture. A new set
  // takes priority over a write-1-to-clear arriving on the same edge.
  always_comb begin
    rise      = db_next & ~db_q;
    fall      = ~db_next & db_q;
    pend_next = (pend_q & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
  end

  // Debounce, pending, and interrupt state registers. irq is built from the
  // registered pending flags, so it trails pending by one cycle. It also
  // trails a change on irq_mask by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      db_q   <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      db_q   <= db_next;
      pend_q <= pend_next;
      irq_q  <= |(pend_q & irq_mask);
    end
  end

  assign gpio_db = db_q;
  assign pending = pend_q;
  assign irq     = irq_q;

endmodule
